// File: rtl/sched_pkg.sv
// sched_pkg: shared types and constants for the round-robin process scheduler.
//   cause_t  - switch cause code driven on switch_cause
//   state_t  - scheduler FSM states
//   *_DEF    - default kernel vectors for each cause
package sched_pkg;
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_QUANTUM = 2'd1,
    CAUSE_IO      = 2'd2,
    CAUSE_EXIT    = 2'd3
  } cause_t;
  // The initial dispatch out of IDLE enters the kernel like a quantum expiry.
  localparam cause_t CAUSE_DISPATCH = CAUSE_QUANTUM;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REQ} state_t;
  localparam int SAVE_ADDR_DEF = 180;
  localparam int IO_ADDR_DEF   = 92;
  localparam int END_ADDR_DEF  = 236;
endpackage

// File: rtl/rr_next_pick.sv
// rr_next_pick: combinational round-robin selector.
//   eligible - bit p-1 set when slot p is active and not blocked
//   cur      - slot to search after (0 = start from slot 1)
//   next     - first eligible slot after cur, wrapping, cur itself last; 0 if none
module rr_next_pick #(
  parameter int NPROC = 10,
  localparam int PID_W = $clog2(NPROC + 1)
) (
  input  logic [NPROC-1:0] eligible,
  input  logic [PID_W-1:0] cur,
  output logic [PID_W-1:0] next
);
  int id;
  // Walk the candidates from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    next = '0;
    id = 0;
    for (int k = NPROC; k >= 1; k--) begin
      id = (int'(cur) + k > NPROC) ? int'(cur) + k - NPROC : int'(cur) + k;
      if (eligible[id-1]) next = PID_W'(id);
    end
  end
endmodule

// File: rtl/round_robin_scheduler.sv
// round_robin_scheduler: quantum/IO/exit driven round-robin context-switch requester.
//   clk, reset (async, active-high)
//   quantum_len                 - retired instructions per quantum, 0 disables preemption
//   pc, retire, io_instr, exit_instr - retiring instruction information
//   admit_valid/admit_id        - kernel loader activates a slot
//   io_done_valid/io_done_id    - unblocks a slot after IO completion
//   switch_ack                  - kernel finished the context switch
//   switch_req/cause/vector     - pending switch request and kernel entry point
//   next_proc/resume_pc         - process to dispatch and its saved PC
//   cur_proc, active_mask, blocked_mask, bound_err - scheduler status
module round_robin_scheduler
  import sched_pkg::*;
#(
  parameter int NPROC = 10,
  parameter int PART_SIZE = 300,
  parameter int PC_W = 32,
  parameter int QW = 8,
  parameter int SAVE_ADDR = SAVE_ADDR_DEF,
  parameter int IO_ADDR = IO_ADDR_DEF,
  parameter int END_ADDR = END_ADDR_DEF,
  localparam int PID_W = $clog2(NPROC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [QW-1:0]    quantum_len,
  input  logic [PC_W-1:0]  pc,
  input  logic             retire,
  input  logic             io_instr,
  input  logic             exit_instr,
  input  logic             admit_valid,
  input  logic [PID_W-1:0] admit_id,
  input  logic             io_done_valid,
  input  logic [PID_W-1:0] io_done_id,
  input  logic             switch_ack,
  output logic             switch_req,
  output logic [1:0]       switch_cause,
  output logic [PC_W-1:0]  switch_vector,
  output logic [PID_W-1:0] next_proc,
  output logic [PC_W-1:0]  resume_pc,
  output logic [PID_W-1:0] cur_proc,
  output logic [NPROC-1:0] active_mask,
  output logic [NPROC-1:0] blocked_mask,
  output logic             bound_err
);
  state_t state, state_n;
  cause_t cause_n;
  logic [QW-1:0] qcount;
  logic [PC_W-1:0] saved_pc [NPROC];
  logic [PC_W-1:0] saved_n [NPROC];
  logic [NPROC-1:0] admit_bit, io_bit, cur_bit, active_n, blocked_n, eligible;
  logic [PID_W-1:0] pick, pick_cur;
  logic [PC_W-1:0] vector_n, resume_n, part_lo;
  logic run_ret, ev_exit, ev_io, ev_q, load_req, ack, refresh, out_of_part;

  // Id 0 and ids above NPROC shift the single bit out of range and yield an empty mask.
  function automatic logic [NPROC-1:0] bit_of(input logic [PID_W-1:0] id);
    return NPROC'(1) << (id - PID_W'(1));
  endfunction

  assign admit_bit = admit_valid ? bit_of(admit_id) : '0;
  assign io_bit = io_done_valid ? bit_of(io_done_id) : '0;
  assign cur_bit = bit_of(cur_proc);
  assign pick_cur = state == S_IDLE ? '0 : cur_proc;

  rr_next_pick #(.NPROC(NPROC)) u_pick (
    .eligible(eligible),
    .cur(pick_cur),
    .next(pick)
  );

  // Mask and saved-PC updates are computed first so selection sees them in the same cycle.
  always_comb begin
    run_ret = state == S_RUN && retire;
    ev_exit = run_ret && exit_instr;
    ev_io = run_ret && !exit_instr && io_instr;
    ev_q = run_ret && !exit_instr && !io_instr && quantum_len != '0 &&
           {1'b0, qcount} + 1'b1 == {1'b0, quantum_len};
    active_n = (active_mask | admit_bit) & ~(ev_exit ? cur_bit : '0);
    blocked_n = (blocked_mask & ~admit_bit & ~io_bit) | (ev_io ? cur_bit : '0);
    eligible = active_n & ~blocked_n;
    resume_n = '0;
    for (int i = 0; i < NPROC; i++) begin
      saved_n[i] = admit_bit[i] ? PC_W'((i + 1) * PART_SIZE) : saved_pc[i];
      if ((ev_io || ev_q) && cur_bit[i]) saved_n[i] = pc + 1'b1;
    end
    for (int i = 0; i < NPROC; i++)
      if (pick == PID_W'(i + 1)) resume_n = saved_n[i];
    load_req = (state == S_IDLE && |eligible) || ev_exit || ev_io || ev_q;
    ack = state == S_REQ && switch_ack;
    refresh = state == S_REQ && !switch_ack && next_proc == '0;
    cause_n = ev_exit ? CAUSE_EXIT : ev_io ? CAUSE_IO : ev_q ? CAUSE_QUANTUM : CAUSE_DISPATCH;
    vector_n = PC_W'(ev_exit ? END_ADDR : ev_io ? IO_ADDR : SAVE_ADDR);
    state_n = load_req ? S_REQ : ack ? (next_proc == '0 ? S_IDLE : S_RUN) : state;
    part_lo = PC_W'(cur_proc) * PC_W'(PART_SIZE);
    out_of_part = pc < part_lo || pc >= part_lo + PC_W'(PART_SIZE);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_mask <= '0;
      blocked_mask <= '0;
      for (int i = 0; i < NPROC; i++) saved_pc[i] <= '0;
      qcount <= '0;
      bound_err <= 1'b0;
      cur_proc <= '0;
      switch_req <= 1'b0;
      switch_cause <= CAUSE_NONE;
      switch_vector <= '0;
      next_proc <= '0;
      resume_pc <= '0;
    end else begin
      active_mask <= active_n;
      blocked_mask <= blocked_n;
      saved_pc <= saved_n;
      bound_err <= bound_err | (run_ret && out_of_part);
      qcount <= ack ? '0 : (run_ret && qcount != '1) ? qcount + 1'b1 : qcount;
      if (load_req) begin
        switch_req <= 1'b1;
        switch_cause <= cause_n;
        switch_vector <= vector_n;
        next_proc <= pick;
        resume_pc <= resume_n;
      end else if (ack) begin
        switch_req <= 1'b0;
        switch_cause <= CAUSE_NONE;
        cur_proc <= next_proc;
      end else if (refresh) begin
        // Nothing was runnable when the request was raised; pick up slots unblocked since.
        next_proc <= pick;
        resume_pc <= resume_n;
      end
    end
  end
endmodule

// File: doc/round_robin_scheduler.md
# round_robin_scheduler

Parametrised round-robin process scheduler for the OS-lab processor: tracks up to NPROC user processes in fixed PART_SIZE-word partitions, counts the quantum in retired instructions, and raises a context-switch request (quantum expiry, IO instruction, process exit) with the kernel vector, the next process, and its saved resume PC. Sits beside the PC register. The PC mux takes `switch_vector` when `switch_req` is high, and the kernel context-switch routine pulses `switch_ack` when finished.

## Interface
- NPROC, 10: user process slots, ids 1..NPROC; id 0 = kernel/BIOS partition.
- PART_SIZE, 300: words per partition; process p owns [p*PART_SIZE, (p+1)*PART_SIZE).
- PC_W, 32: PC width.
- QW, 8: quantum counter width.
- SAVE_ADDR, 180 / IO_ADDR, 92 / END_ADDR, 236: kernel vectors for quantum / IO / exit causes.
- PID_W, $clog2(NPROC+1): derived process-id width.

Ports:
- clk  in  1  system clock (divided CPU clock).
- reset  in  1  asynchronous, active-high.
- quantum_len  in  QW  instructions per quantum; 0 disables preemption.
- pc  in  PC_W  PC of the retiring instruction.
- retire  in  1  one instruction retired this cycle (low while halted).
- io_instr, exit_instr  in  1  retiring instruction is IN/OUT, or process end; qualified by retire.
- admit_valid  in  1  activate slot admit_id (kernel loader).
- admit_id  in  PID_W  slot to activate.
- io_done_valid  in  1  unblock slot io_done_id.
- io_done_id  in  PID_W  slot whose IO completed.
- switch_ack  in  1  kernel finished the switch; one-cycle pulse.
- switch_req  out  1  context switch pending; reset 0.
- switch_cause  out  2  cause code; reset NONE.
- switch_vector  out  PC_W  kernel vector for the cause; reset 0.
- next_proc  out  PID_W  process to dispatch (0 = none runnable); reset 0.
- resume_pc  out  PC_W  saved PC of next_proc; reset 0.
- cur_proc  out  PID_W  running process; reset 0.
- active_mask, blocked_mask  out  NPROC  bit p-1 = slot p; reset 0.
- bound_err  out  1  sticky: pc outside cur_proc partition while RUN; reset 0.

## Operation
- States are IDLE, RUN and REQ. Reset enters IDLE, clears all masks, counter, saved-PC table and outputs.
- Admit sets active[id] and clears blocked[id]. It loads saved_pc[id] = id*PART_SIZE. Ids 0 and >NPROC are ignored. Admitting an already-active slot reloads its PC.
- IDLE: if any slot is active and unblocked, go to REQ with cause DISPATCH, vector SAVE_ADDR, and next = lowest eligible id.
- RUN: on retire, qcount increments, saturating.
  - Exit (priority 1): clear active[cur]; go to REQ with cause EXIT and vector END_ADDR.
  - IO (priority 2): set blocked[cur]; saved_pc[cur] = pc+1; cause IO, vector IO_ADDR.
  - Quantum (priority 3): when quantum_len != 0 and qcount+1 == quantum_len, saved_pc[cur] = pc+1; cause QUANTUM, vector SAVE_ADDR.
- Next-process selection (sub-module): first active&~blocked id strictly after cur, wrapping NPROC→1. cur itself is chosen last if still eligible. Returns 0 if none is eligible. On QUANTUM with a single eligible process, next_proc = cur.
- REQ: switch_req held high, with cause, vector, next_proc and resume_pc = saved_pc[next_proc] stable until switch_ack.
  - On ack: cur_proc ← next_proc, qcount ← 0, state ← RUN, or IDLE if next_proc = 0.
  - retire is ignored in REQ.
- io_done clears blocked[id] in any state. If it arrives in REQ with next_proc = 0, next_proc/resume_pc are re-evaluated the following cycle. Otherwise outputs are frozen while in REQ.
- Same-cycle admit/io_done with a retire event: mask updates apply first, then selection sees the new masks.
- bound_err: sets when retire in RUN and pc ∉ [cur*PART_SIZE, (cur+1)*PART_SIZE). Clears only on reset.

## Timing
- A switch event on retire at edge N gives switch_req=1 after edge N (registered, latency 1). next_proc and resume_pc are valid in the same cycle.
- An ack sampled at edge M gives switch_req=0 and the cur_proc update after M. A new request can be raised no earlier than M+1.
- Ack while switch_req=0 is ignored.
- Reset mid-REQ drops switch_req asynchronously.
- The saved-PC table is written at the same edge that raises switch_req.

## Structure
- Package `sched_pkg`: cause encoding NONE=0, QUANTUM=1, IO=2, EXIT=3, plus DISPATCH=QUANTUM with vector SAVE_ADDR; state enum; default vector constants.
- Sub-module `rr_next_pick` (combinational, parameter NPROC): inputs eligible mask and cur; outputs next id.
- The saved-PC table is an NPROC×PC_W register array.

## Test plan
- Admit 1 and 2, quantum_len=3 → DISPATCH next=1, resume_pc=300. Ack, 3 retires → QUANTUM next=2, resume_pc=600, saved_pc[1]=303.
- Process 2 retires IN at pc=605 → cause IO, vector 92, blocked_mask=0b10. next=1 resume 303. io_done(2) clears bit.
- Only process 1 active, quantum expires → next_proc=1 (self), resume_pc = pc+1.
- Process 1 exits with 2 blocked → next_proc=0, vector 236. io_done(2) while in REQ → next_proc=2 the next cycle.
- quantum_len=0: 1000 retires → no switch. pc=50 while cur=1 → bound_err=1.
- Reset asserted while switch_req=1 → all outputs 0 immediately, state IDLE, masks clear.
